// File: rtl/uart_tx_multi.sv
// Multi-character UART transmitter: sends a NUM_BYTES-wide word as consecutive
// 8N1/8P1/8N2/8P2 characters, least significant byte first, with optional parity.
// Latency: the start bit begins on the edge that samples wr; o_done pulses
// NUM_BYTES*(10+PARITY_EN+STOP_BITS-1)*CLKS_PER_BIT clocks after that edge.
// Backpressure: wr is accepted only while idle (o_busy=0); writes during a frame are dropped.
//
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   i_data  parallel word, latched on an accepted write
//   wr      one-cycle write strobe
//   o_busy  high from the accept edge until the frame completes
//   o_done  one-cycle pulse on frame completion (same edge o_busy falls)
//   s_out   serial line, idles high
module uart_tx_multi #(
  parameter int CLKS_PER_BIT = 5,
  parameter int NUM_BYTES    = 2,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [8*NUM_BYTES-1:0] i_data,
  input  logic                   wr,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   s_out
);

  localparam int IDXW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [7:0]      CNT_LAST  = 8'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [7:0]               clk_cnt_q, clk_cnt_d;
  logic [2:0]               bit_cnt_q, bit_cnt_d;
  logic [IDXW-1:0]          byte_idx_q, byte_idx_d;
  logic [8*NUM_BYTES-1:0]   shreg_q, shreg_d;
  logic                     s_out_q, s_out_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic [7:0] cur_byte;
  logic       bit_last;
  logic       parity_bit;

  // Byte currently on the wire; the latched word is never shifted, only indexed.
  always_comb begin
    cur_byte = 8'h00;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (byte_idx_q == IDXW'(i)) cur_byte = shreg_q[8*i +: 8];
    end
  end

  assign bit_last   = (clk_cnt_q == CNT_LAST);
  assign parity_bit = (^cur_byte) ^ (PARITY_ODD != 0);

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      clk_cnt_q  <= 8'd0;
      bit_cnt_q  <= 3'd0;
      byte_idx_q <= '0;
      shreg_q    <= '0;
      s_out_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      shreg_q    <= shreg_d;
      s_out_q    <= s_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state and counter logic. bit_cnt indexes data bits in DATA and
  // counts stop bits in STOP, so the clock counter never exceeds one bit time.
  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    shreg_d    = shreg_q;
    if (state_q == S_IDLE) begin
      if (wr) begin
        state_d    = S_START;
        shreg_d    = i_data;
        byte_idx_d = '0;
        clk_cnt_d  = 8'd0;
        bit_cnt_d  = 3'd0;
      end
    end else if (!bit_last) begin
      clk_cnt_d = clk_cnt_q + 8'd1;
    end else begin
      clk_cnt_d = 8'd0;
      unique case (state_q)
        S_START: begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd0;
        end
        S_DATA: begin
          if (bit_cnt_q == 3'd7) begin
            state_d   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            bit_cnt_d = 3'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        S_PARITY: begin
          state_d   = S_STOP;
          bit_cnt_d = 3'd0;
        end
        S_STOP: begin
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = 3'd0;
            if (byte_idx_q == IDX_LAST) begin
              state_d = S_IDLE;
            end else begin
              state_d    = S_START;
              byte_idx_d = byte_idx_q + IDXW'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Registered outputs are computed from the state being entered, so the
  // line changes on the same edge as the state transition.
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_STOP) && (state_d == S_IDLE);
    unique case (state_d)
      S_START:  s_out_d = 1'b0;
      S_DATA:   s_out_d = cur_byte[bit_cnt_d];
      S_PARITY: s_out_d = parity_bit;
      default:  s_out_d = 1'b1;
    endcase
  end

  assign s_out  = s_out_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_uart_tx_multi.sv
// Bench for uart_tx_multi: five configurations run side by side against a
// frame-level model that expands each accepted word into its per-clock line levels.
module tb_uart_tx_multi;

  localparam int N = 5;

  logic        clk;
  logic        rst_n;
  logic        wr   [N];
  logic [63:0] dat  [N];
  logic        so   [N];
  logic        busy [N];
  logic        done [N];

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  // 0: defaults  1: 8E1 one byte  2: 8O1 one byte  3: two stop bits
  // 4: one clock per bit, three bytes, odd parity, two stop bits
  uart_tx_multi u0 (.clk(clk), .rst_n(rst_n), .i_data(dat[0][15:0]), .wr(wr[0]),
                    .o_busy(busy[0]), .o_done(done[0]), .s_out(so[0]));
  uart_tx_multi #(.NUM_BYTES(1), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .rst_n(rst_n), .i_data(dat[1][7:0]), .wr(wr[1]),
    .o_busy(busy[1]), .o_done(done[1]), .s_out(so[1]));
  uart_tx_multi #(.NUM_BYTES(1), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk(clk), .rst_n(rst_n), .i_data(dat[2][7:0]), .wr(wr[2]),
    .o_busy(busy[2]), .o_done(done[2]), .s_out(so[2]));
  uart_tx_multi #(.STOP_BITS(2)) u3 (
    .clk(clk), .rst_n(rst_n), .i_data(dat[3][15:0]), .wr(wr[3]),
    .o_busy(busy[3]), .o_done(done[3]), .s_out(so[3]));
  uart_tx_multi #(.CLKS_PER_BIT(1), .NUM_BYTES(3), .PARITY_EN(1), .PARITY_ODD(1),
                  .STOP_BITS(2)) u4 (
    .clk(clk), .rst_n(rst_n), .i_data(dat[4][23:0]), .wr(wr[4]),
    .o_busy(busy[4]), .o_done(done[4]), .s_out(so[4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int p_cpb(input int id);
    return (id == 4) ? 1 : 5;
  endfunction
  function automatic int p_nb(input int id);
    case (id)
      1, 2:    return 1;
      4:       return 3;
      default: return 2;
    endcase
  endfunction
  function automatic int p_pen(input int id);
    return (id == 1 || id == 2 || id == 4) ? 1 : 0;
  endfunction
  function automatic int p_odd(input int id);
    return (id == 2 || id == 4) ? 1 : 0;
  endfunction
  function automatic int p_stop(input int id);
    return (id == 3 || id == 4) ? 2 : 1;
  endfunction

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // ---------------- model ----------------
  bit mline [N][0:1023];
  int mlen  [N];
  int mpos  [N];
  bit mbusy [N];
  bit e_line[N];
  bit e_busy[N];
  bit e_done[N];

  // Expand a word into line levels: per character start, 8 data bits LSB first,
  // optional parity, stop bits; each level repeated for one bit time.
  task automatic build(input int id, input logic [63:0] d);
    int n;
    logic [7:0] by;
    bit lv [$];
    lv = {};
    for (int b = 0; b < p_nb(id); b++) begin
      by = d[8*b +: 8];
      lv.push_back(1'b0);
      for (int j = 0; j < 8; j++) lv.push_back(by[j]);
      if (p_pen(id) != 0) lv.push_back((^by) ^ (p_odd(id) != 0));
      for (int s = 0; s < p_stop(id); s++) lv.push_back(1'b1);
    end
    n = 0;
    foreach (lv[k]) for (int c = 0; c < p_cpb(id); c++) begin
      mline[id][n] = lv[k];
      n++;
    end
    mlen[id] = n;
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        mbusy[i] = 0; e_line[i] = 1; e_busy[i] = 0; e_done[i] = 0;
      end else if (!mbusy[i]) begin
        e_done[i] = 0;
        if (wr[i] === 1'b1) begin
          build(i, dat[i]);
          e_line[i] = mline[i][0];
          mpos[i]   = 1;
          mbusy[i]  = 1;
        end else begin
          e_line[i] = 1;
        end
        e_busy[i] = mbusy[i];
      end else if (mpos[i] < mlen[i]) begin
        e_line[i] = mline[i][mpos[i]];
        mpos[i]++;
      end else begin
        mbusy[i] = 0; e_busy[i] = 0; e_done[i] = 1; e_line[i] = 1;
      end
    end
  end

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("u%0d_s_out", i), int'(so[i]), int'(e_line[i]));
        check($sformatf("u%0d_busy", i), int'(busy[i]), int'(e_busy[i]));
        check($sformatf("u%0d_done", i), int'(done[i]), int'(e_done[i]));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  bit cap [0:1023];

  // Send one word; capture the line at each falling edge after the accept edge.
  // cap[k] is the level k cycles after acceptance; done_at is the first k with o_done.
  task automatic send(input int id, input logic [63:0] d, input int inj_at,
                      input int limit, output int busy_n, output int done_n,
                      output int done_at);
    @(negedge clk);
    dat[id] = d;
    wr[id]  = 1'b1;
    @(posedge clk);
    #1 wr[id] = 1'b0;
    busy_n = 0; done_n = 0; done_at = -1;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (k == inj_at) begin
        wr[id]  = 1'b1;
        dat[id] = 64'hFFFF_FFFF_FFFF_FFFF;
      end else if (k == inj_at + 1) begin
        wr[id] = 1'b0;
      end
      cap[k] = so[id];
      if (busy[id] === 1'b1) busy_n++;
      if (done[id] === 1'b1) begin
        done_n++;
        if (done_at < 0) done_at = k;
      end
    end
  endtask

  // Compare the captured line with a hand-written bit sequence (MSB first).
  task automatic check_wave(input string name, input logic [19:0] pat, input int cpb);
    int bad;
    bad = 0;
    for (int k = 0; k < 20 * cpb; k++)
      if (cap[k] !== pat[19 - k / cpb]) bad++;
    check(name, bad, 0);
  endtask

  int bn, dn, da;
  logic [19:0] pat_a53c;
  int done_k [3];

  initial begin
    pat_a53c = 20'b0001111001_0101001011;
    for (int i = 0; i < N; i++) begin
      wr[i]  = 1'b0;
      dat[i] = 64'h0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_s_out_u%0d", i), int'(so[i]), 1);
      check($sformatf("rst_busy_u%0d", i), int'(busy[i]), 0);
      check($sformatf("rst_done_u%0d", i), int'(done[i]), 0);
    end
    chk_en = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: defaults, A53C
    send(0, 64'hA53C, -10, 105, bn, dn, da);
    check("s1_busy_clocks", bn, 100);
    check("s1_done_pulses", dn, 1);
    check("s1_done_at", da, 100);
    check_wave("s1_waveform", pat_a53c, 5);

    // 2: even / odd parity on 3C
    send(1, 64'h3C, -10, 60, bn, dn, da);
    check("s2e_parity_bit", int'(cap[47]), 0);
    check("s2e_stop_bit", int'(cap[50]), 1);
    check("s2e_done_at", da, 55);
    check("s2e_busy_clocks", bn, 55);
    send(2, 64'h3C, -10, 60, bn, dn, da);
    check("s2o_parity_bit", int'(cap[47]), 1);
    check("s2o_done_at", da, 55);

    // 3: two stop bits between characters
    send(3, 64'hA53C, -10, 115, bn, dn, da);
    begin
      int hi;
      hi = 0;
      for (int k = 45; k < 55; k++) if (cap[k] === 1'b1) hi++;
      check("s3_inter_char_high", hi, 10);
    end
    check("s3_second_start", int'(cap[55]), 0);
    check("s3_done_at", da, 110);

    // 4: write with new data at clock 30 is ignored
    send(0, 64'hA53C, 30, 105, bn, dn, da);
    check_wave("s4_waveform", pat_a53c, 5);
    check("s4_done_at", da, 100);
    check("s4_done_pulses", dn, 1);

    // one clock per bit, three characters
    send(4, 64'h0A0B03, -10, 40, bn, dn, da);
    check("cpb1_parity_b0", int'(cap[9]), 1);
    check("cpb1_stop_b0", int'(cap[11]), 1);
    check("cpb1_start_b1", int'(cap[12]), 0);
    check("cpb1_done_at", da, 36);

    // 5: asynchronous reset 42 clocks into a frame
    @(negedge clk);
    dat[0] = 64'hA53C;
    wr[0]  = 1'b1;
    @(posedge clk);
    #1 wr[0] = 1'b0;
    repeat (42) @(posedge clk);
    #2;
    check("s5_line_before_rst", int'(so[0]), 0);
    rst_n = 1'b0;
    #1;
    check("s5_async_s_out", int'(so[0]), 1);
    check("s5_async_busy", int'(busy[0]), 0);
    check("s5_async_done", int'(done[0]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("s5_idle_after_rst", int'(so[0]), 1);
    send(0, 64'hA53C, -10, 105, bn, dn, da);
    check_wave("s5_clean_waveform", pat_a53c, 5);
    check("s5_done_at", da, 100);

    // 6: wr held high for three frames, data changed in each done cycle
    @(negedge clk);
    dat[0] = 64'h1234;
    wr[0]  = 1'b1;
    bn = 0; dn = 0;
    for (int k = 0; k < 320; k++) begin
      @(negedge clk);
      cap[k] = so[0];
      if (busy[0] === 1'b1) bn++;
      if (done[0] === 1'b1) begin
        if (dn < 3) done_k[dn] = k;
        dn++;
        if (dn == 1) dat[0] = 64'h00FF;
        if (dn == 2) dat[0] = 64'h8001;
        if (dn >= 3) wr[0] = 1'b0;
      end
    end
    wr[0] = 1'b0;
    check("s6_done_pulses", dn, 3);
    check("s6_busy_clocks", bn, 300);
    check("s6_done0", done_k[0], 100);
    check("s6_done1", done_k[1], 201);
    check("s6_done2", done_k[2], 302);
    check("s6_f1_bit0", int'(cap[6]), 0);
    check("s6_f2_bit0", int'(cap[106]), 1);
    check("s6_f3_bit0", int'(cap[207]), 1);
    check("s6_done_cycle_line", int'(cap[100]), 1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
